// File: rtl/ascon_pkg.sv
// Shared types, round-constant table and rounds_sel decode for the Ascon
// permutation stream block.
package ascon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PERM  = 2'd2,
    ST_DRAIN = 2'd3
  } ascon_fsm_e;

  typedef logic [63:0] ascon_word_t;

  // Index 0 is S0, which occupies the most significant 64 bits.
  typedef logic [0:4][63:0] ascon_state_t;

  // c_i = {4'hF - i, i}
  localparam logic [7:0] ASCON_RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return (idx < 4'd12) ? ASCON_RC[idx] : 8'h00;
  endfunction

  // Rounds_sel: 00=12, 01=8, 10=6, 11=the configured default.
  function automatic logic [3:0] ascon_nr(input logic [1:0] sel,
                                          input int unsigned def);
    logic [3:0] nr;
    case (sel)
      2'b00:   nr = 4'd12;
      2'b01:   nr = 4'd8;
      2'b10:   nr = 4'd6;
      default: nr = 4'(def);
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bit-sliced 5-bit S-box,
// then per-word linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t i_s,
  input  logic [7:0]   i_rc,
  output ascon_state_t o_s
);

  ascon_state_t w_c, w_s, w_t, w_u;

  // Constant addition into the low byte of S2.
  always_comb begin
    w_c    = i_s;
    w_c[2] = i_s[2] ^ {56'd0, i_rc};
  end

  // S-box input mixing.
  always_comb begin
    w_s    = w_c;
    w_s[0] = w_c[0] ^ w_c[4];
    w_s[4] = w_c[4] ^ w_c[3];
    w_s[2] = w_c[2] ^ w_c[1];
  end

  // Chi-like nonlinear layer.
  always_comb begin
    w_t[0] = w_s[0] ^ (~w_s[1] & w_s[2]);
    w_t[1] = w_s[1] ^ (~w_s[2] & w_s[3]);
    w_t[2] = w_s[2] ^ (~w_s[3] & w_s[4]);
    w_t[3] = w_s[3] ^ (~w_s[4] & w_s[0]);
    w_t[4] = w_s[4] ^ (~w_s[0] & w_s[1]);
  end

  // S-box output mixing.
  always_comb begin
    w_u[0] = w_t[0] ^ w_t[4];
    w_u[1] = w_t[1] ^ w_t[0];
    w_u[2] = ~w_t[2];
    w_u[3] = w_t[3] ^ w_t[2];
    w_u[4] = w_t[4];
  end

  // Linear diffusion with the Ascon rotation pairs.
  always_comb begin
    o_s[0] = w_u[0] ^ {w_u[0][18:0], w_u[0][63:19]} ^ {w_u[0][27:0], w_u[0][63:28]};
    o_s[1] = w_u[1] ^ {w_u[1][60:0], w_u[1][63:61]} ^ {w_u[1][38:0], w_u[1][63:39]};
    o_s[2] = w_u[2] ^ {w_u[2][0],    w_u[2][63:1]}  ^ {w_u[2][5:0],  w_u[2][63:6]};
    o_s[3] = w_u[3] ^ {w_u[3][9:0],  w_u[3][63:10]} ^ {w_u[3][16:0], w_u[3][63:17]};
    o_s[4] = w_u[4] ^ {w_u[4][6:0],  w_u[4][63:7]}  ^ {w_u[4][40:0], w_u[4][63:41]};
  end

endmodule

// File: rtl/ascon_perm_stream.sv
// Streaming Ascon permutation: load 320-bit state in DATA_W beats, apply
// NR rounds, drain it back out in the same beat order.
// Optional macro ASCON_DUAL_ROUND_EN: two cascaded rounds per PERM cycle.
module ascon_perm_stream
  import ascon_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ROUNDS_DEF = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rounds_sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned NB      = 320 / DATA_W;
  localparam logic [5:0]  NB_LAST = 6'(NB - 1);

`ifdef ASCON_DUAL_ROUND_EN
  localparam logic [3:0] STEP = 4'd2;
`else
  localparam logic [3:0] STEP = 4'd1;
`endif
  localparam logic [3:0] RND_LAST = 4'd12 - STEP;

  ascon_fsm_e   r_st, w_st_nxt;
  logic [319:0] r_state, w_state_nxt;
  logic [5:0]   r_cnt, w_cnt_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic [3:0]   r_nr, w_nr_nxt;

  ascon_state_t w_r0_in, w_r0_out;
  logic [7:0]   w_rc0;
  logic [319:0] w_perm;

  assign w_r0_in = r_state;
  assign w_rc0   = ascon_rc(r_rnd);

  ascon_round u_round0 (
    .i_s  (w_r0_in),
    .i_rc (w_rc0),
    .o_s  (w_r0_out)
  );

`ifdef ASCON_DUAL_ROUND_EN
  ascon_state_t w_r1_out;
  logic [7:0]   w_rc1;

  // Round counter starts even (0, 4 or 6), so r_rnd+1 never passes 11.
  assign w_rc1 = ascon_rc(r_rnd + 4'd1);

  ascon_round u_round1 (
    .i_s  (w_r0_out),
    .i_rc (w_rc1),
    .o_s  (w_r1_out)
  );

  assign w_perm = w_r1_out;
`else
  assign w_perm = w_r0_out;
`endif

  // Output decode from the current state.
  always_comb begin
    in_ready  = (r_st == ST_IDLE) || (r_st == ST_LOAD);
    out_valid = (r_st == ST_DRAIN);
    busy      = (r_st != ST_IDLE);
    out_data  = out_valid ? r_state[319 -: DATA_W] : '0;
  end

  // Next-state logic: shift-register load/drain, round application in PERM.
  always_comb begin
    w_st_nxt    = r_st;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rnd_nxt   = r_rnd;
    w_nr_nxt    = r_nr;
    case (r_st)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = {r_state[319-DATA_W:0], in_data};
          w_cnt_nxt   = 6'd1;
          w_nr_nxt    = ascon_nr(rounds_sel, ROUNDS_DEF);
          w_st_nxt    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          w_state_nxt = {r_state[319-DATA_W:0], in_data};
          if (r_cnt == NB_LAST) begin
            w_cnt_nxt = '0;
            w_rnd_nxt = 4'd12 - r_nr;
            w_st_nxt  = ST_PERM;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      ST_PERM: begin
        w_state_nxt = w_perm;
        if (r_rnd == RND_LAST) begin
          w_rnd_nxt = '0;
          w_st_nxt  = ST_DRAIN;
        end else begin
          w_rnd_nxt = r_rnd + STEP;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          w_state_nxt = {r_state[319-DATA_W:0], {DATA_W{1'b0}}};
          if (r_cnt == NB_LAST) begin
            w_cnt_nxt = '0;
            w_st_nxt  = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 6'd1;
          end
        end
      end
      default: w_st_nxt = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st    <= ST_IDLE;
      r_state <= '0;
      r_cnt   <= '0;
      r_rnd   <= '0;
      r_nr    <= '0;
    end else begin
      r_st    <= w_st_nxt;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rnd   <= w_rnd_nxt;
      r_nr    <= w_nr_nxt;
    end
  end

endmodule

// File: tb/tb_ascon_perm_stream.sv
// Scoreboard bench for ascon_perm_stream at DATA_W = 16, 8 and 64.
module tb_ascon_perm_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] rsel;

  logic [7:0]  in8,  od8;
  logic [15:0] in16, od16;
  logic [63:0] in64, od64;
  logic iv8, ir8, ov8, or8, bz8;
  logic iv16, ir16, ov16, or16, bz16;
  logic iv64, ir64, ov64, or64, bz64;

  ascon_perm_stream #(.DATA_W(16), .ROUNDS_DEF(12)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_data(in16), .in_valid(iv16), .in_ready(ir16),
    .rounds_sel(rsel), .out_data(od16), .out_valid(ov16), .out_ready(or16), .busy(bz16));
  ascon_perm_stream #(.DATA_W(8), .ROUNDS_DEF(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_data(in8), .in_valid(iv8), .in_ready(ir8),
    .rounds_sel(rsel), .out_data(od8), .out_valid(ov8), .out_ready(or8), .busy(bz8));
  ascon_perm_stream #(.DATA_W(64), .ROUNDS_DEF(6)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_data(in64), .in_valid(iv64), .in_ready(ir64),
    .rounds_sel(rsel), .out_data(od64), .out_valid(ov64), .out_ready(or64), .busy(bz64));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] q [$];

  // Ascon S-box, input bit 4 = x0.
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  task automatic chkd(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(string tag, int obs, int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(logic [63:0] x, int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] model(logic [319:0] s, int nr);
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [4:0]  v, y;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    for (int r = 12 - nr; r < 12; r++) begin
      x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
      for (int b = 0; b < 64; b++) begin
        v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        y = SBOX[v];
        t[0][b] = y[4]; t[1][b] = y[3]; t[2][b] = y[2]; t[3][b] = y[1]; t[4][b] = y[0];
      end
      x[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
      x[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
      x[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
      x[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
      x[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int nr_of(int w, logic [1:0] sel);
    case (sel)
      2'b00: return 12;
      2'b01: return 8;
      2'b10: return 6;
      default: return (w == 16) ? 12 : (w == 8) ? 8 : 6;
    endcase
  endfunction

  function automatic int exp_lat(int nr);
`ifdef ASCON_DUAL_ROUND_EN
    return nr / 2 + 1;
`else
    return nr + 1;
`endif
  endfunction

  function automatic logic [63:0] beat(logic [319:0] s, int w, int k);
    logic [319:0] t;
    t = s << (k * w);
    return t[319:256] >> (64 - w);
  endfunction

  task automatic set_in(int w, logic v, logic [63:0] d);
    case (w)
      8:       begin iv8  = v; in8  = d[7:0];  end
      16:      begin iv16 = v; in16 = d[15:0]; end
      default: begin iv64 = v; in64 = d;       end
    endcase
  endtask

  task automatic set_or(int w, logic r);
    case (w)
      8:       or8  = r;
      16:      or16 = r;
      default: or64 = r;
    endcase
  endtask

  function automatic logic [63:0] get_od(int w);
    case (w)
      8:       return {56'd0, od8};
      16:      return {48'd0, od16};
      default: return od64;
    endcase
  endfunction

  function automatic logic get_ov(int w);
    return (w == 8) ? ov8 : (w == 16) ? ov16 : ov64;
  endfunction

  function automatic logic get_ir(int w);
    return (w == 8) ? ir8 : (w == 16) ? ir16 : ir64;
  endfunction

  function automatic logic get_bz(int w);
    return (w == 8) ? bz8 : (w == 16) ? bz16 : bz64;
  endfunction

  // Called at a negedge with the DUT idle; returns one negedge after the last
  // presented beat. A complete load pushes the golden drain beats.
  task automatic load(int w, logic [319:0] st, logic [1:0] sel,
                      bit gaps, bit hold, int stop_at);
    int nb;
    logic [319:0] g;
    nb   = 320 / w;
    rsel = sel;
    if (stop_at < 0) begin
      g = model(st, nr_of(w, sel));
      for (int k = 0; k < nb; k++) q.push_back(beat(g, w, k));
    end
    for (int k = 0; k < nb; k++) begin
      if (k == stop_at) return;
      if (gaps && (k % 3 == 1)) begin
        set_in(w, 1'b0, '0);
        @(negedge clk);
      end
      chkb("in_ready_load", get_ir(w), 1'b1);
      set_in(w, 1'b1, beat(st, w, k));
      @(negedge clk);
      rsel = ~sel;
    end
    set_in(w, hold, 64'hdeadbeefcafef00d);
  endtask

  task automatic wait_out(int w, output int lat, output int perm);
    lat  = 1;
    perm = 0;
    while (!get_ov(w) && lat < 200) begin
      if (get_bz(w)) perm++;
      chkb("in_ready_perm", get_ir(w), 1'b0);
      chkd("out_data_zero", get_od(w), 64'd0);
      @(negedge clk);
      lat++;
    end
    chkb("out_valid_timeout", get_ov(w), 1'b1);
  endtask

  task automatic drain(int w, int stall_beat, int stall_n);
    int nb, t;
    logic [63:0] exp;
    nb = 320 / w;
    for (int k = 0; k < nb; k++) begin
      set_or(w, 1'b0);
      t = 0;
      while (!get_ov(w) && t < 50) begin
        @(negedge clk);
        t++;
      end
      chkb("drain_valid", get_ov(w), 1'b1);
      chkb("in_ready_drain", get_ir(w), 1'b0);
      exp = (q.size() > 0) ? q.pop_front() : 64'hbad0bad0bad0bad0;
      chkd("drain_data", get_od(w), exp);
      if (k == stall_beat) begin
        for (int j = 0; j < stall_n; j++) begin
          @(negedge clk);
          chkb("stall_valid", get_ov(w), 1'b1);
          chkd("stall_hold", get_od(w), exp);
        end
      end
      set_or(w, 1'b1);
      @(negedge clk);
    end
    set_or(w, 1'b0);
    chkb("idle_busy", get_bz(w), 1'b0);
    chkb("idle_in_ready", get_ir(w), 1'b1);
    chkb("no_extra_beat", get_ov(w), 1'b0);
    chki("sb_empty", q.size(), 0);
  endtask

  initial begin
    int lat, perm, ws [2];
    logic [319:0] st;
    logic [1:0]   sel;

    rst_n = 1'b0; rsel = 2'b00;
    set_in(8, 1'b0, '0); set_in(16, 1'b0, '0); set_in(64, 1'b0, '0);
    set_or(8, 1'b0); set_or(16, 1'b0); set_or(64, 1'b0);
    repeat (3) @(negedge clk);
    chkb("rst_in_ready", ir16, 1'b1);
    chkb("rst_out_valid", ov16, 1'b0);
    chkd("rst_out_data", {48'd0, od16}, 64'd0);
    chkb("rst_busy", bz16, 1'b0);
    chkb("rst_busy_w8", bz8, 1'b0);
    chkb("rst_busy_w64", bz64, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero state, 12 rounds.
    load(16, '0, 2'b00, 1'b0, 1'b0, -1);
    wait_out(16, lat, perm);
    chki("lat_p12", lat, exp_lat(12));
    drain(16, -1, 0);

    // IV-like state, 6 rounds, load gaps and a drain stall on beat 3.
    st = {64'h80400c0600000000, 256'd0};
    load(16, st, 2'b10, 1'b1, 1'b0, -1);
    wait_out(16, lat, perm);
    chki("perm_cycles_p6", perm, exp_lat(6) - 1);
    drain(16, 3, 5);

    // Reset at load beat 7.
    st = {$urandom, $urandom, $urandom, $urandom, $urandom,
          $urandom, $urandom, $urandom, $urandom, $urandom};
    load(16, st, 2'b00, 1'b0, 1'b0, 7);
    rst_n = 1'b0;
    set_in(16, 1'b1, beat(st, 16, 7));
    @(negedge clk);
    rst_n = 1'b1;
    set_in(16, 1'b0, '0);
    chkb("rst_load_busy", bz16, 1'b0);
    chkb("rst_load_in_ready", ir16, 1'b1);

    // Reset at PERM cycle 4.
    load(16, st, 2'b01, 1'b0, 1'b0, -1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chkb("rst_perm_busy", bz16, 1'b0);
    chkb("rst_perm_in_ready", ir16, 1'b1);
    chkb("rst_perm_out_valid", ov16, 1'b0);
    q.delete();

    // Fresh full load after resets, default round count.
    load(16, st, 2'b11, 1'b0, 1'b0, -1);
    wait_out(16, lat, perm);
    chki("lat_p12_def", lat, exp_lat(12));
    drain(16, -1, 0);

    // in_valid held high through PERM and DRAIN.
    st = ~st;
    load(16, st, 2'b01, 1'b0, 1'b1, -1);
    wait_out(16, lat, perm);
    drain(16, -1, 0);
    @(negedge clk);
    chkb("idle_accepts_beat", bz16, 1'b1);
    rst_n = 1'b0;
    set_in(16, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    chkb("rst_after_hold_busy", bz16, 1'b0);

    // Random states at DATA_W = 8 and 64.
    ws[0] = 8; ws[1] = 64;
    for (int wi = 0; wi < 2; wi++) begin
      for (int it = 0; it < 200; it++) begin
        st  = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
        sel = 2'($urandom_range(0, 3));
        load(ws[wi], st, sel, (it % 5) == 0, 1'b0, -1);
        wait_out(ws[wi], lat, perm);
        chki("lat_rand", lat, exp_lat(nr_of(ws[wi], sel)));
        drain(ws[wi], (it % 7 == 0) ? 2 : -1, 2);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
